// File: rtl/circle_seg_pkg.sv
// Shared segment patterns and animation mode encoding for the circle display driver.
package circle_seg_pkg;

   // {dp, g, f, e, d, c, b, a}
   localparam logic [7:0] SEG_TOP = 8'b0110_0011;
   localparam logic [7:0] SEG_BOT = 8'b0101_1100;
   localparam logic [7:0] SEG_OFF = 8'b0000_0000;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'd0,
      MODE_CHASE  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_BLANK  = 2'd3
   } circle_mode_t;

endpackage

// File: rtl/tick_div.sv
// Synchronous prescaler: counts 0..DIV-1 while enabled, tick is the combinational wrap event.
module tick_div #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/circle_chase_seg.sv
// Animates a top/bottom circle across N_DIGITS multiplexed 7-segment digits with
// static, chase and bounce modes; one-hot digit scan and registered outputs.
module circle_chase_seg #(
   parameter int N_DIGITS = 4,
   parameter int SCAN_DIV = 50000,
   parameter int STEP_DIV = 12500000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [1:0]          mode,
   input  logic                row,
   input  logic                dir,
   output logic [7:0]          seg_display,
   output logic [N_DIGITS-1:0] digit_sel,
   output logic                step_tick
);
   import circle_seg_pkg::*;

   localparam int NP = 2 * N_DIGITS;
   localparam int PW = $clog2(NP);
   localparam int SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(NP - 1);
   localparam logic [PW-1:0] P_N    = PW'(N_DIGITS);
   localparam logic [SW-1:0] S_LAST = SW'(N_DIGITS - 1);

   circle_mode_t  mode_e;
   logic [1:0]    mode_q;
   logic          mode_chg;
   logic          step_raw;
   logic          step_ev;
   logic          scan_tick;
   logic [PW-1:0] p;
   logic [PW-1:0] p_nxt;
   logic          bdir;
   logic          bdir_nxt;
   logic [SW-1:0] s;
   logic          lit_top;
   logic [SW-1:0] lit_digit;
   logic [7:0]    pat;

   assign mode_e   = circle_mode_t'(mode);
   assign mode_chg = (mode != mode_q);
   // A mode-change clear wins over a coincident step event.
   assign step_ev  = step_raw && !mode_chg;

   tick_div #(.DIV(SCAN_DIV)) u_scan_div (
      .clk  (clk),
      .rst  (rst),
      .en   (1'b1),
      .clr  (1'b0),
      .tick (scan_tick)
   );

   tick_div #(.DIV(STEP_DIV)) u_step_div (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (mode_chg),
      .tick (step_raw)
   );

   // mode_q only tracks the input so no change is seen straight out of reset.
   always_ff @(posedge clk) begin
      mode_q <= mode;
   end

   always_comb begin
      p_nxt    = p;
      bdir_nxt = bdir;
      if (mode_chg) begin
         p_nxt    = '0;
         bdir_nxt = 1'b0;
      end else if (step_ev) begin
         case (mode_e)
            MODE_CHASE: begin
               if (dir) p_nxt = (p == '0) ? P_LAST : p - 1'b1;
               else     p_nxt = (p == P_LAST) ? '0 : p + 1'b1;
            end
            MODE_BOUNCE: begin
               if (!bdir) begin
                  if (p == P_LAST) begin
                     bdir_nxt = 1'b1;
                     p_nxt    = P_LAST - 1'b1;
                  end else begin
                     p_nxt = p + 1'b1;
                  end
               end else begin
                  if (p == '0) begin
                     bdir_nxt = 1'b0;
                     p_nxt    = PW'(1);
                  end else begin
                     p_nxt = p - 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      lit_top   = (p < P_N);
      lit_digit = lit_top ? SW'(p) : SW'(P_LAST - p);
      case (mode_e)
         MODE_STATIC: pat = row ? SEG_TOP : SEG_BOT;
         MODE_CHASE,
         MODE_BOUNCE: pat = (s == lit_digit) ? (lit_top ? SEG_TOP : SEG_BOT) : SEG_OFF;
         default:     pat = SEG_OFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p           <= '0;
         bdir        <= 1'b0;
         s           <= '0;
         step_tick   <= 1'b0;
         seg_display <= SEG_OFF;
         digit_sel   <= '0;
      end else begin
         p         <= p_nxt;
         bdir      <= bdir_nxt;
         step_tick <= step_ev;
         if (scan_tick) begin
            s <= (s == S_LAST) ? '0 : s + 1'b1;
         end
         if (en) begin
            seg_display <= pat;
            digit_sel   <= N_DIGITS'(1) << s;
         end else begin
            seg_display <= SEG_OFF;
            digit_sel   <= '0;
         end
      end
   end

endmodule
